// File: rtl/alu_serial_seq_if.sv
// Request/response bus between the operand/decode stage and the bit-serial ALU sequencer.
// Start acts as valid and ~Busy as ready; Done is a one-cycle strobe marking Result/flags valid.
interface alu_serial_seq_if #(
  parameter int WIDTH = 24
);
  logic             Start;
  logic [2:0]       AluCtrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             CarryOut;
  logic             Zero;
  logic             Overflow;

  modport master (
    output Start, AluCtrl, A, B,
    input  Busy, Done, Result, CarryOut, Zero, Overflow
  );

  modport slave (
    input  Start, AluCtrl, A, B,
    output Busy, Done, Result, CarryOut, Zero, Overflow
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a 1-bit ALU slice, LSB first, one bit per cycle; SLT is a subtract pass plus a fix-up cycle.
// Optional signed overflow / corrected SLT enabled by defining ALU_SERIAL_OVERFLOW_EN.
module alu_serial_seq #(
  parameter int WIDTH = 24
) (
  input  logic                Clock,
  input  logic                ResetN,
  alu_serial_seq_if.slave     bus,
  output logic                SliceA,
  output logic                SliceB,
  output logic                SliceCin,
  output logic                SliceBInvert,
  output logic                SliceLess,
  output logic [1:0]          SliceOp,
  input  logic                SliceResult,
  input  logic                SliceCarryOut,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef ALU_SERIAL_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SLTFIX = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] res_sh_q, res_sh_d;
  logic             diff_msb_q, diff_msb_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             is_slt, is_arith, last_bit, slt_set;
  logic [2:0]       ctrl_in;
  logic [WIDTH-1:0] word;

  assign is_slt   = (ctrl_q == 3'b111);
  assign is_arith = (ctrl_q[1:0] == 2'b10) || is_slt;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign ctrl_in  = (bus.AluCtrl == 3'b011) ? 3'b111 : bus.AluCtrl;
  // The final slice result is still in flight on the last RUN edge, so it is merged in here.
  assign word     = {SliceResult, res_sh_q};
  assign slt_set  = diff_msb_q ^ (OVF_EN & (cin_msb_q ^ carry_q));

  always_comb begin
    SliceA       = 1'b0;
    SliceB       = 1'b0;
    SliceCin     = 1'b0;
    SliceBInvert = 1'b0;
    SliceLess    = 1'b0;
    SliceOp      = 2'b00;
    if (state_q == RUN) begin
      SliceA       = a_sh_q[0];
      SliceB       = b_sh_q[0];
      SliceCin     = carry_q;
      SliceBInvert = ctrl_q[2];
      SliceOp      = is_slt ? 2'b10 : ctrl_q[1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    cin_msb_d  = cin_msb_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    diff_msb_d = diff_msb_q;
    ctrl_d     = ctrl_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          ctrl_d  = ctrl_in;
          a_sh_d  = bus.A;
          b_sh_d  = bus.B;
          carry_d = ctrl_in[2];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_sh_d = {SliceResult, res_sh_q[WIDTH-2:1]};
        carry_d  = SliceCarryOut;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB, needed for signed overflow.
          cin_msb_d  = carry_q;
          diff_msb_d = SliceResult;
          if (is_slt) begin
            state_d = SLTFIX;
          end else begin
            result_d = word;
            zero_d   = (word == '0);
            cout_d   = is_arith & SliceCarryOut;
            ovf_d    = OVF_EN & is_arith & (carry_q ^ SliceCarryOut);
            state_d  = DONE;
          end
        end
      end
      SLTFIX: begin
        result_d = {{(WIDTH-1){1'b0}}, slt_set};
        zero_d   = ~slt_set;
        cout_d   = carry_q;
        ovf_d    = OVF_EN & (cin_msb_q ^ carry_q);
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      cin_msb_q  <= 1'b0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      diff_msb_q <= 1'b0;
      ctrl_q     <= 3'b000;
      result_q   <= '0;
      zero_q     <= 1'b1;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      cin_msb_q  <= cin_msb_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      diff_msb_q <= diff_msb_d;
      ctrl_q     <= ctrl_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = (state_q == DONE);
  assign bus.Result   = result_q;
  assign bus.Zero     = zero_q;
  assign bus.CarryOut = cout_q;
  assign bus.Overflow = ovf_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: behavioural 1-bit slice, arithmetic reference model,
// directed cases, mid-run reset, ignored Start, back-to-back throughput and random ops.
module tb_alu_serial_seq;
  localparam int WIDTH = 24;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_serial_seq_if #(.WIDTH(WIDTH)) bus();

  logic       slice_a, slice_b, slice_cin, slice_binv, slice_less;
  logic [1:0] slice_op;
  logic       slice_res, slice_cout;
  logic [1:0] dbg_state;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .Clock        (clk),
    .ResetN       (rst_n),
    .bus          (bus.slave),
    .SliceA       (slice_a),
    .SliceB       (slice_b),
    .SliceCin     (slice_cin),
    .SliceBInvert (slice_binv),
    .SliceLess    (slice_less),
    .SliceOp      (slice_op),
    .SliceResult  (slice_res),
    .SliceCarryOut(slice_cout),
    .dbg_state    (dbg_state)
  );

  // Behavioural 1-bit ALU slice
  logic slice_bb;
  always_comb begin
    slice_bb   = slice_b ^ slice_binv;
    slice_cout = (slice_a & slice_bb) | (slice_a & slice_cin) | (slice_bb & slice_cin);
    case (slice_op)
      2'b00:   slice_res = slice_a & slice_bb;
      2'b01:   slice_res = slice_a | slice_bb;
      2'b10:   slice_res = slice_a ^ slice_bb ^ slice_cin;
      default: slice_res = slice_less;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH+2:0] exp_q[$];
  logic [WIDTH-1:0] got_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: {result, carry, zero, overflow} from plain arithmetic
  function automatic logic [WIDTH+2:0] ref_model(input logic [2:0] ctrl,
                                                  input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2:0]       c;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             co, ov, lt;
    c  = (ctrl == 3'b011) ? 3'b111 : ctrl;
    co = 1'b0;
    ov = 1'b0;
    r  = '0;
    case (c)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: r = a & ~b;
      3'b101: r = a | ~b;
      3'b010: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[WIDTH-1:0];
        co  = sum[WIDTH];
        ov  = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        r   = sum[WIDTH-1:0];
        co  = sum[WIDTH];
        ov  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        if (c == 3'b111) begin
`ifdef ALU_SERIAL_OVERFLOW_EN
          lt = ($signed(a) < $signed(b));
`else
          lt = sum[WIDTH-1];
`endif
          r = {{(WIDTH-1){1'b0}}, lt};
        end
      end
    endcase
`ifndef ALU_SERIAL_OVERFLOW_EN
    ov = 1'b0;
`endif
    return {r, co, (r == '0), ov};
  endfunction

  // Expected slice drive in RUN cycle k: {A, B, Cin, BInvert, Less, Op}
  function automatic logic [6:0] slice_exp(input logic [2:0] ctrl, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b, input int k);
    logic [2:0]      c;
    logic [WIDTH-1:0] bp;
    longint unsigned mask, s;
    logic            cin;
    c    = (ctrl == 3'b011) ? 3'b111 : ctrl;
    bp   = c[2] ? ~b : b;
    mask = (longint'(1) << k) - 1;
    s    = (longint'(a) & mask) + (longint'(bp) & mask) + longint'(c[2]);
    cin  = s[k];
    return {a[k], b[k], cin, c[2], 1'b0, (c == 3'b111) ? 2'b10 : c[1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [2:0] ctrl, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int poke);
    logic [WIDTH+2:0] e;
    int cyc;
    bit slt;
    @(negedge clk);
    bus.AluCtrl = ctrl;
    bus.A       = a;
    bus.B       = b;
    bus.Start   = 1'b1;
    exp_q.push_back(ref_model(ctrl, a, b));
    slt = (ctrl == 3'b111) || (ctrl == 3'b011);
    @(negedge clk);
    bus.Start = 1'b0;
    cyc = 0;
    check("busy_run", bus.Busy, 1'b1);
    while (!bus.Done && cyc < 4 * WIDTH) begin
      if (cyc < WIDTH)
        check("slice", {slice_a, slice_b, slice_cin, slice_binv, slice_less, slice_op},
              slice_exp(ctrl, a, b, cyc));
      if (cyc == poke) begin
        bus.Start   = 1'b1;
        bus.A       = ~a;
        bus.B       = a;
        bus.AluCtrl = 3'b001;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.Start = 1'b0;
    check("latency", cyc, slt ? WIDTH + 1 : WIDTH);
    e       = exp_q.pop_front();
    got_res = bus.Result;
    check("result",   bus.Result,   e[WIDTH+2:3]);
    check("carryout", bus.CarryOut, e[2]);
    check("zero",     bus.Zero,     e[1]);
    check("overflow", bus.Overflow, e[0]);
    @(negedge clk);
    check("idle_after", {bus.Busy, bus.Done}, 2'b00);
    check("held",       bus.Result, e[WIDTH+2:3]);
  endtask

  task automatic reset_mid_run();
    bit done_seen;
    @(negedge clk);
    bus.AluCtrl = 3'b010;
    bus.A       = 24'h000101;
    bus.B       = 24'h000001;
    bus.Start   = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy",   bus.Busy,     1'b0);
    check("rst_done",   bus.Done,     1'b0);
    check("rst_result", bus.Result,   24'h000000);
    check("rst_zero",   bus.Zero,     1'b1);
    check("rst_cout",   bus.CarryOut, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (3 * WIDTH) begin
      @(negedge clk);
      if (bus.Done) done_seen = 1'b1;
    end
    check("rst_no_done", done_seen, 1'b0);
  endtask

  task automatic back_to_back();
    logic [WIDTH+2:0] e;
    int t, d1, d2;
    e  = ref_model(3'b010, 24'h00ABCD, 24'h001111);
    d1 = -1;
    d2 = -1;
    @(negedge clk);
    bus.AluCtrl = 3'b010;
    bus.A       = 24'h00ABCD;
    bus.B       = 24'h001111;
    bus.Start   = 1'b1;
    for (t = 0; t < 4 * WIDTH && d2 < 0; t++) begin
      @(negedge clk);
      if (bus.Done) begin
        check("b2b_result", bus.Result, e[WIDTH+2:3]);
        if (d1 < 0) d1 = t;
        else        d2 = t;
      end
    end
    bus.Start = 1'b0;
    check("b2b_gap", d2 - d1, WIDTH + 2);
    repeat (WIDTH + 4) @(negedge clk);
    check("b2b_idle", bus.Busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.Start   = 1'b0;
    bus.AluCtrl = 3'b000;
    bus.A       = '0;
    bus.B       = '0;
    repeat (3) @(negedge clk);
    check("reset_result", bus.Result,   24'h000000);
    check("reset_zero",   bus.Zero,     1'b1);
    check("reset_cout",   bus.CarryOut, 1'b0);
    check("reset_ovf",    bus.Overflow, 1'b0);
    check("reset_busy",   bus.Busy,     1'b0);
    check("reset_done",   bus.Done,     1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'b010, 24'h000005, 24'h000003, -1); check("add_5_3",   got_res, 24'h000008);
    run_op(3'b110, 24'h000003, 24'h000003, -1); check("sub_eq",    got_res, 24'h000000);
    run_op(3'b010, 24'hFFFFFF, 24'h000001, -1); check("add_wrap",  got_res, 24'h000000);
    run_op(3'b111, 24'h000002, 24'h000005, -1); check("slt_lt",    got_res, 24'h000001);
    run_op(3'b111, 24'h000005, 24'h000002, -1); check("slt_ge",    got_res, 24'h000000);
    run_op(3'b111, 24'h7FFFFF, 24'h800000, -1);
`ifdef ALU_SERIAL_OVERFLOW_EN
    check("slt_ovf", {got_res, bus.Overflow}, {24'h000000, 1'b1});
`else
    check("slt_ovf", {got_res, bus.Overflow}, {24'h000001, 1'b0});
`endif
    run_op(3'b000, 24'hF0F0F0, 24'h0FF0FF, -1); check("and_pat",   got_res, 24'h00F0F0);
    run_op(3'b001, 24'hF0F0F0, 24'h0FF0FF, -1); check("or_pat",    got_res, 24'hFFF0FF);
    run_op(3'b100, 24'hF0F0F0, 24'h0FF0FF, -1);
    run_op(3'b101, 24'hF0F0F0, 24'h0FF0FF, -1);
    run_op(3'b011, 24'h800000, 24'h000001, -1);
    run_op(3'b010, 24'h123456, 24'h111111, 5);  check("poke_ign",  got_res, 24'h234567);

    reset_mid_run();
    back_to_back();

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom), -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
